// File: rtl/nms_pkg.sv
// Shared definitions for the NMS host sequencer: FSM encoding and the
// NMS core register map.
package nms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_IOU    = 3'd1,
    ST_WR_S      = 3'd2,
    ST_WR_START  = 3'd3,
    ST_STREAM    = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_WR_CLR    = 3'd6,
    ST_RESULT    = 3'd7
  } state_t;

  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_IOU  = 4'h4;
  localparam logic [3:0] ADDR_S    = 4'h8;

endpackage

// File: rtl/nms_host_sequencer_if.sv
// Signal bundle around the NMS host sequencer; the master side issues jobs,
// boxes and completion, the slave side is the sequencer itself.
interface nms_host_sequencer_if #(
  parameter int BBOX_DATA_WIDTH  = 64,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int BBOX_IND_WIDTH   = 14,
  parameter int REG_ADDR_WIDTH   = 4,
  parameter int IOU_THRESH_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH   = 10
) (
  input logic clk
);

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [BBOX_IND_WIDTH-1:0]   cmd_num_pred;
  logic [IOU_THRESH_WIDTH-1:0] cmd_iou;
  logic [IOU_THRESH_WIDTH-1:0] cmd_s;
  logic                        box_valid;
  logic                        box_ready;
  logic [BBOX_DATA_WIDTH-1:0]  box_data;
  logic                        reg_ren;
  logic [REG_ADDR_WIDTH-1:0]   reg_addr;
  logic [REG_DATA_WIDTH-1:0]   reg_data;
  logic                        pbox_ren;
  logic [BBOX_DATA_WIDTH-1:0]  pred_bbox_data;
  logic                        nms_done;
  logic [REG_DATA_WIDTH-1:0]   num_box_data;
  logic                        res_valid;
  logic                        res_ready;
  logic [MEM_ADDR_WIDTH-1:0]   res_count;
  logic                        busy;

  modport master (
    input  clk,
    output cmd_valid, cmd_num_pred, cmd_iou, cmd_s,
    output box_valid, box_data, nms_done, num_box_data, res_ready,
    input  cmd_ready, box_ready, reg_ren, reg_addr, reg_data,
    input  pbox_ren, pred_bbox_data, res_valid, res_count, busy
  );

  modport slave (
    input  clk,
    input  cmd_valid, cmd_num_pred, cmd_iou, cmd_s,
    input  box_valid, box_data, nms_done, num_box_data, res_ready,
    output cmd_ready, box_ready, reg_ren, reg_addr, reg_data,
    output pbox_ren, pred_bbox_data, res_valid, res_count, busy
  );

endinterface

// File: rtl/nms_host_sequencer.sv
// Host-side job sequencer for the NMS core: programs thresholds, starts the
// core, streams boxes into it, waits for completion and returns the count.
//
// state        | meaning
// IDLE         | waiting for a job command (cmd_ready high)
// WR_IOU       | writing the IoU threshold register
// WR_S         | writing the score threshold register
// WR_START     | writing control with the start bit set
// STREAM       | forwarding num_pred boxes to the core
// WAIT_DONE    | waiting for the core completion pulse
// WR_CLR       | writing control with the start bit cleared
// RESULT       | presenting the kept-box count until accepted
module nms_host_sequencer
  import nms_pkg::*;
#(
  parameter int BBOX_DATA_WIDTH  = 64,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int BBOX_IND_WIDTH   = 14,
  parameter int REG_ADDR_WIDTH   = 4,
  parameter int IOU_THRESH_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH   = 10
) (
  input  logic                        clk,
  input  logic                        gen_rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [BBOX_IND_WIDTH-1:0]   cmd_num_pred,
  input  logic [IOU_THRESH_WIDTH-1:0] cmd_iou,
  input  logic [IOU_THRESH_WIDTH-1:0] cmd_s,
  input  logic                        box_valid,
  output logic                        box_ready,
  input  logic [BBOX_DATA_WIDTH-1:0]  box_data,
  output logic                        reg_ren,
  output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
  output logic [REG_DATA_WIDTH-1:0]   reg_data,
  output logic                        pbox_ren,
  output logic [BBOX_DATA_WIDTH-1:0]  pred_bbox_data,
  input  logic                        nms_done,
  input  logic [REG_DATA_WIDTH-1:0]   num_box_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [MEM_ADDR_WIDTH-1:0]   res_count,
  output logic                        busy
);

  state_t                      state;
  logic [BBOX_IND_WIDTH-1:0]   num_pred;
  logic [BBOX_IND_WIDTH-1:0]   box_cnt;
  logic [BBOX_IND_WIDTH-1:0]   box_cnt_inc;
  logic [IOU_THRESH_WIDTH-1:0] iou;
  logic [IOU_THRESH_WIDTH-1:0] s;
  logic                        done_flag;
  logic                        unused_box_hi;

  // Only the low MEM_ADDR_WIDTH bits of the core's count are meaningful.
  assign unused_box_hi = ^num_box_data[REG_DATA_WIDTH-1:MEM_ADDR_WIDTH];
  assign box_cnt_inc   = BBOX_IND_WIDTH'(box_cnt + 1'b1);

  // Outputs are set for the state being entered, so each one is a flop.
  always_ff @(posedge clk or negedge gen_rst_n) begin
    if (!gen_rst_n) begin
      state          <= ST_IDLE;
      num_pred       <= '0;
      box_cnt        <= '0;
      iou            <= '0;
      s              <= '0;
      done_flag      <= 1'b0;
      cmd_ready      <= 1'b1;
      box_ready      <= 1'b0;
      reg_ren        <= 1'b0;
      reg_addr       <= '0;
      reg_data       <= '0;
      pbox_ren       <= 1'b0;
      pred_bbox_data <= '0;
      res_valid      <= 1'b0;
      res_count      <= '0;
      busy           <= 1'b0;
    end else begin
      reg_ren  <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      pbox_ren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            num_pred  <= cmd_num_pred;
            iou       <= cmd_iou;
            s         <= cmd_s;
            done_flag <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            reg_ren   <= 1'b1;
            reg_addr  <= REG_ADDR_WIDTH'(ADDR_IOU);
            reg_data  <= REG_DATA_WIDTH'(cmd_iou);
            state     <= ST_WR_IOU;
          end
        end
        ST_WR_IOU: begin
          reg_ren  <= 1'b1;
          reg_addr <= REG_ADDR_WIDTH'(ADDR_S);
          reg_data <= REG_DATA_WIDTH'(s);
          state    <= ST_WR_S;
        end
        ST_WR_S: begin
          reg_ren  <= 1'b1;
          reg_addr <= REG_ADDR_WIDTH'(ADDR_CTRL);
          reg_data <= REG_DATA_WIDTH'({num_pred, 1'b1});
          state    <= ST_WR_START;
        end
        ST_WR_START: begin
          box_cnt <= '0;
          if (num_pred == '0) begin
            state <= ST_WAIT_DONE;
          end else begin
            box_ready <= 1'b1;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (nms_done) begin
            done_flag <= 1'b1;
            res_count <= num_box_data[MEM_ADDR_WIDTH-1:0];
          end
          if (box_valid && box_ready) begin
            pbox_ren       <= 1'b1;
            pred_bbox_data <= box_data;
            box_cnt        <= box_cnt_inc;
            if (box_cnt_inc == num_pred) begin
              box_ready <= 1'b0;
              state     <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (nms_done) begin
            done_flag <= 1'b1;
            res_count <= num_box_data[MEM_ADDR_WIDTH-1:0];
          end
          if (nms_done || done_flag) begin
            reg_ren  <= 1'b1;
            reg_addr <= REG_ADDR_WIDTH'(ADDR_CTRL);
            reg_data <= REG_DATA_WIDTH'({num_pred, 1'b0});
            state    <= ST_WR_CLR;
          end
        end
        ST_WR_CLR: begin
          res_valid <= 1'b1;
          state     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          box_ready <= 1'b0;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nms_host_sequencer.sv
// Scoreboard bench for nms_host_sequencer: jobs are described by their
// parameters, expected writes/boxes/results are queued and a monitor checks them.
module tb_nms_host_sequencer;

  logic clk = 1'b0;
  logic gen_rst_n = 1'b1;
  always #5 clk = ~clk;

  nms_host_sequencer_if bus (.clk(clk));

  nms_host_sequencer dut (
    .clk            (clk),
    .gen_rst_n      (gen_rst_n),
    .cmd_valid      (bus.cmd_valid),
    .cmd_ready      (bus.cmd_ready),
    .cmd_num_pred   (bus.cmd_num_pred),
    .cmd_iou        (bus.cmd_iou),
    .cmd_s          (bus.cmd_s),
    .box_valid      (bus.box_valid),
    .box_ready      (bus.box_ready),
    .box_data       (bus.box_data),
    .reg_ren        (bus.reg_ren),
    .reg_addr       (bus.reg_addr),
    .reg_data       (bus.reg_data),
    .pbox_ren       (bus.pbox_ren),
    .pred_bbox_data (bus.pred_bbox_data),
    .nms_done       (bus.nms_done),
    .num_box_data   (bus.num_box_data),
    .res_valid      (bus.res_valid),
    .res_ready      (bus.res_ready),
    .res_count      (bus.res_count),
    .busy           (bus.busy)
  );

  typedef struct {logic [3:0] addr; logic [31:0] data; int at;} wr_t;
  typedef struct {logic [63:0] d; int at;} box_t;

  wr_t        wr_q[$];
  box_t       box_q[$];
  logic [9:0] res_q[$];
  wr_t        mw;
  box_t       mb;
  logic [9:0] mr;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  logic zero_job = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: settles just after the falling edge so driven inputs are stable.
  always @(negedge clk) begin
    #2;
    if (mon_en && gen_rst_n) begin
      if (bus.reg_ren) begin
        if (wr_q.size() == 0) fail_now("reg_unexpected_write");
        else begin
          mw = wr_q.pop_front();
          check("reg_addr", 64'(bus.reg_addr), 64'(mw.addr));
          check("reg_data", 64'(bus.reg_data), 64'(mw.data));
          if (mw.at >= 0) check("reg_cycle", 64'(cyc), 64'(mw.at));
        end
      end else begin
        check("reg_idle_zero", 64'({bus.reg_addr, bus.reg_data}), 64'd0);
      end
      if (bus.pbox_ren) begin
        if (box_q.size() == 0) fail_now("pbox_unexpected");
        else begin
          mb = box_q.pop_front();
          check("pbox_data", bus.pred_bbox_data, mb.d);
          check("pbox_cycle", 64'(cyc), 64'(mb.at));
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (res_q.size() == 0) fail_now("res_unexpected");
        else begin
          mr = res_q.pop_front();
          check("res_count", 64'(bus.res_count), 64'(mr));
        end
      end
      if (zero_job) check("box_ready_zero_job", 64'(bus.box_ready), 64'd0);
    end
  end

  task automatic run_job(input int np, input logic [15:0] iou, input logic [15:0] s,
                         input int nbox, input int done_at, input bit toggle, input int hold);
    int  n, sent, k;
    bit  done_sent;
    logic [63:0] d;
    @(negedge clk);
    bus.cmd_num_pred = 14'(np);
    bus.cmd_iou      = iou;
    bus.cmd_s        = s;
    bus.cmd_valid    = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin fail_now("cmd_ready_timeout"); bus.cmd_valid = 1'b0; return; end
    n = cyc;
    wr_q.push_back('{4'h4, 32'(iou), n + 1});
    wr_q.push_back('{4'h8, 32'(s), n + 2});
    wr_q.push_back('{4'h0, 32'(np * 2 + 1), n + 3});
    wr_q.push_back('{4'h0, 32'(np * 2), -1});
    res_q.push_back(10'(nbox % 1024));
    zero_job = (np == 0);
    if (np == 0) bus.box_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    sent = 0; k = 0; done_sent = 0;
    while (sent < np && k < 2000) begin
      @(negedge clk);
      k++;
      bus.nms_done = 1'b0;
      bus.num_box_data = $urandom;
      if (!done_sent && done_at == sent && done_at < np && bus.box_ready) begin
        bus.nms_done = 1'b1;
        bus.num_box_data = 32'(nbox);
        done_sent = 1;
      end
      bus.box_valid = toggle ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      bus.box_data = d;
      if (bus.box_valid && bus.box_ready) begin
        box_q.push_back('{d, cyc + 1});
        sent++;
      end
    end
    if (k >= 2000) fail_now("stream_timeout");
    @(negedge clk);
    bus.box_valid = 1'b0;
    bus.nms_done  = 1'b0;
    if (!done_sent) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.nms_done = 1'b1;
      bus.num_box_data = 32'(nbox);
      @(negedge clk);
      bus.nms_done = 1'b0;
      bus.num_box_data = $urandom;
    end
    k = 0;
    while (!bus.res_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin fail_now("res_valid_timeout"); zero_job = 1'b0; return; end
    repeat (hold) begin
      check("res_hold_valid", 64'(bus.res_valid), 64'd1);
      check("res_hold_count", 64'(bus.res_count), 64'(nbox % 1024));
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    zero_job = 1'b0;
    check("post_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("post_busy", 64'(bus.busy), 64'd0);
    check("post_res_valid", 64'(bus.res_valid), 64'd0);
  endtask

  task automatic reset_mid_stream();
    logic [63:0] d;
    int k;
    @(negedge clk);
    bus.cmd_num_pred = 14'd6;
    bus.cmd_iou = 16'h1234;
    bus.cmd_s = 16'h0042;
    bus.cmd_valid = 1'b1;
    wr_q.push_back('{4'h4, 32'h1234, cyc + 1});
    wr_q.push_back('{4'h8, 32'h0042, cyc + 2});
    wr_q.push_back('{4'h0, 32'd13, cyc + 3});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    k = 0;
    while (k < 2) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      bus.box_data = d;
      bus.box_valid = 1'b1;
      if (bus.box_ready) begin box_q.push_back('{d, cyc + 1}); k++; end
    end
    @(negedge clk);
    bus.box_valid = 1'b0;
    check("pre_reset_box_ready", 64'(bus.box_ready), 64'd1);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #3;
    gen_rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_reg_ren", 64'(bus.reg_ren), 64'd0);
    check("rst_pbox_ren", 64'(bus.pbox_ren), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_box_ready", 64'(bus.box_ready), 64'd0);
    check("rst_pending_writes", 64'(wr_q.size()), 64'd0);
    wr_q.delete();
    box_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    gen_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("after_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("after_rst_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    bus.cmd_valid = 1'b0;
    bus.cmd_num_pred = '0;
    bus.cmd_iou = '0;
    bus.cmd_s = '0;
    bus.box_valid = 1'b0;
    bus.box_data = '0;
    bus.nms_done = 1'b0;
    bus.num_box_data = '0;
    bus.res_ready = 1'b0;
    #2;
    gen_rst_n = 1'b0;
    #1;
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_reg_ren", 64'(bus.reg_ren), 64'd0);
    check("reset_box_ready", 64'(bus.box_ready), 64'd0);
    check("reset_pbox_ren", 64'(bus.pbox_ren), 64'd0);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_res_count", 64'(bus.res_count), 64'd0);
    repeat (2) @(negedge clk);
    gen_rst_n = 1'b1;
    mon_en = 1'b1;

    run_job(3, 16'h8000, 16'h4000, 2, 3, 1'b1, 5);
    run_job(0, 16'h0101, 16'h0202, 7, 0, 1'b0, 2);
    run_job(4, 16'hffff, 16'h0001, 1030, 1, 1'b0, 1);
    run_job(2, 16'h0010, 16'h0020, 3, 1, 1'b1, 0);
    reset_mid_stream();
    run_job(1, 16'h7777, 16'h8888, 1023, 1, 1'b0, 1);
    for (int j = 0; j < 12; j++) begin
      np = $urandom_range(0, 8);
      run_job(np, 16'($urandom), 16'($urandom), int'($urandom_range(0, 5000)),
              int'($urandom_range(0, np)), 1'b0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("end_wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("end_box_queue_empty", 64'(box_q.size()), 64'd0);
    check("end_res_queue_empty", 64'(res_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
